// File: rtl/note_recorder.sv
// Song-sheet recorder: stores {note, duration} entries while in record mode.
// Optional REC_LEAD_TRIM_EN drops leading silence via an ARMED state.
module note_recorder #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned TICK_DIV = 8,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned DUR_W    = 8,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         mode,
  input  logic               rec_key,
  input  logic [4:0]         note_in,
  input  logic [AW-1:0]      rd_addr,
  output logic [5+DUR_W-1:0] rd_data,
  output logic [AW:0]        rec_len,
  output logic               recording,
  output logic               full
);

  localparam int unsigned TICK_CYC = CLK_FREQ / TICK_DIV;
  localparam int unsigned TW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_CYC - 1);
  localparam logic [DUR_W-1:0] DUR_MAX   = '1;
  localparam logic [AW:0]      LEN_LAST  = (AW+1)'(DEPTH - 1);
  localparam logic [2:0]       MODE_REC  = 3'b100;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_RECORD = 2'd2;
  localparam logic [1:0] S_FULL   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rec_len_q, rec_len_d;
  logic [4:0]         cur_note_q, cur_note_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [5+DUR_W-1:0] rd_data_q;
  logic [5+DUR_W-1:0] wdata;
  logic               we;
  logic               rec_mode;
  logic               wrap;

  logic [5+DUR_W-1:0] mem [DEPTH];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rec_len_d  = rec_len_q;
    cur_note_d = cur_note_q;
    dur_d      = dur_q;
    tick_d     = tick_q;
    we         = 1'b0;
    wdata      = {cur_note_q, dur_q};
    rec_mode   = (mode == MODE_REC);
    wrap       = (tick_q == TICK_LAST);

    case (state_q)
      S_IDLE: begin
        if (rec_key && rec_mode) begin
          wr_ptr_d   = '0;
          rec_len_d  = '0;
          cur_note_d = note_in;
          dur_d      = '0;
          tick_d     = '0;
`ifdef REC_LEAD_TRIM_EN
          state_d    = S_ARMED;
`else
          state_d    = S_RECORD;
`endif
        end
      end
      S_ARMED: begin
        if (rec_key || !rec_mode) begin
          state_d = S_IDLE;
        end else if (note_in != '0) begin
          state_d    = S_RECORD;
          cur_note_d = note_in;
          dur_d      = '0;
          tick_d     = '0;
        end
      end
      S_RECORD: begin
        tick_d = wrap ? '0 : tick_q + 1'b1;
        if (rec_key || !rec_mode) begin
          we      = (dur_q != '0);
          state_d = S_IDLE;
        end else if (note_in != cur_note_q) begin
          we         = (dur_q != '0);
          cur_note_d = note_in;
          dur_d      = '0;
          tick_d     = '0;
        end else if (wrap) begin
          // The wrap that brings dur to its maximum emits a full-length entry at once.
          if (dur_q == DUR_MAX - 1'b1) begin
            we    = 1'b1;
            wdata = {cur_note_q, DUR_MAX};
            dur_d = '0;
          end else begin
            dur_d = dur_q + 1'b1;
          end
        end
        if (we) begin
          wr_ptr_d  = wr_ptr_q + 1'b1;
          rec_len_d = rec_len_q + 1'b1;
          if (rec_len_q == LEN_LAST && state_d == S_RECORD) state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (rec_key || !rec_mode) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rec_len_q  <= '0;
      cur_note_q <= '0;
      dur_q      <= '0;
      tick_q     <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rec_len_q  <= rec_len_d;
      cur_note_q <= cur_note_d;
      dur_q      <= dur_d;
      tick_q     <= tick_d;
      rd_data_q  <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= wdata;
  end

  assign rd_data   = rd_data_q;
  assign rec_len   = rec_len_q;
  assign recording = (state_q == S_ARMED) || (state_q == S_RECORD);
  assign full      = (state_q == S_FULL);

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder with a 10-cycle tick, 4-entry sheet, 4-bit duration.
module tb_note_recorder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] mode = 3'b000;
  logic       rec_key = 1'b0;
  logic [4:0] note_in = '0;
  logic [1:0] rd_addr = '0;
  logic [8:0] rd_data;
  logic [2:0] rec_len;
  logic       recording;
  logic       full;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  note_recorder #(
    .CLK_FREQ(80),
    .TICK_DIV(8),
    .DEPTH   (4),
    .DUR_W   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .rec_key  (rec_key),
    .note_in  (note_in),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rec_len  (rec_len),
    .recording(recording),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [4:0] n, input int unsigned cycles);
    note_in = n;
    repeat (cycles) cyc();
  endtask

  // Event cycle that starts the first note; with lead trim an extra ARMED cycle is spent.
  task automatic start_rec(input logic [4:0] n);
    note_in = n;
    rec_key = 1'b1;
    cyc();
    rec_key = 1'b0;
`ifdef REC_LEAD_TRIM_EN
    cyc();
`endif
  endtask

  task automatic stop_rec();
    rec_key = 1'b1;
    cyc();
    rec_key = 1'b0;
  endtask

  task automatic read_entry(input logic [1:0] a, input logic [8:0] exp, input string tag);
    rd_addr = a;
    cyc();
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    #2;
    check("rst_recording", 32'(recording), 32'd0);
    check("rst_rec_len",   32'(rec_len),   32'd0);
    check("rst_rd_data",   32'(rd_data),   32'd0);
    check("rst_full",      32'(full),      32'd0);
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    mode = 3'b100;

    // Two notes then stop
    start_rec(5'd8);
    check("t1_recording", 32'(recording), 32'd1);
    run(5'd8, 30);
    run(5'd12, 1);
    check("t1_len_mid", 32'(rec_len), 32'd1);
    run(5'd12, 20);
    stop_rec();
    check("t1_len", 32'(rec_len), 32'd2);
    check("t1_idle", 32'(recording), 32'd0);
    read_entry(2'd0, 9'h083, "t1_e0");
    read_entry(2'd1, 9'h0C2, "t1_e1");

    // Short note is filtered out
    start_rec(5'd9);
    run(5'd9, 5);
    run(5'd10, 21);
    stop_rec();
    check("t2_len", 32'(rec_len), 32'd1);
    read_entry(2'd0, 9'h0A2, "t2_e0");

    // Long note splits at maximum duration
    start_rec(5'd11);
    run(5'd11, 170);
    stop_rec();
    check("t3_len", 32'(rec_len), 32'd2);
    read_entry(2'd0, 9'h0BF, "t3_e0");
    read_entry(2'd1, 9'h0B2, "t3_e1");

    // Sheet fills after four entries
    start_rec(5'd1);
    run(5'd1, 10);
    run(5'd2, 11);
    run(5'd3, 11);
    run(5'd4, 11);
    check("t4_not_full", 32'(full), 32'd0);
    run(5'd5, 1);
    check("t4_full", 32'(full), 32'd1);
    check("t4_full_rec", 32'(recording), 32'd0);
    check("t4_len_full", 32'(rec_len), 32'd4);
    run(5'd5, 10);
    run(5'd6, 11);
    stop_rec();
    check("t4_full_exit", 32'(full), 32'd0);
    check("t4_len", 32'(rec_len), 32'd4);
    read_entry(2'd0, 9'h011, "t4_e0");
    read_entry(2'd1, 9'h021, "t4_e1");
    read_entry(2'd2, 9'h031, "t4_e2");
    read_entry(2'd3, 9'h041, "t4_e3");

    // Asynchronous reset mid-recording
    start_rec(5'd6);
    run(5'd6, 25);
    check("t5_pre_rd", 32'(rd_data), 32'h041);
    #2 rst = 1'b1;
    #1;
    check("t5_recording", 32'(recording), 32'd0);
    check("t5_len", 32'(rec_len), 32'd0);
    check("t5_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    cyc();
    read_entry(2'd0, 9'h011, "t5_mem_kept");

    // Leaving record mode flushes, then rec_key outside record mode is ignored
    start_rec(5'd7);
    run(5'd7, 20);
    mode = 3'b000;
    cyc();
    check("t6_len", 32'(rec_len), 32'd1);
    check("t6_idle", 32'(recording), 32'd0);
    stop_rec();
    check("t6_key_ignored", 32'(recording), 32'd0);
    check("t6_len_kept", 32'(rec_len), 32'd1);
    read_entry(2'd0, 9'h072, "t6_e0");
    mode = 3'b100;

    // rec_key together with a note change gives one flush of the old note
    start_rec(5'd3);
    run(5'd3, 10);
    note_in = 5'd4;
    stop_rec();
    check("t7_len", 32'(rec_len), 32'd1);
    check("t7_idle", 32'(recording), 32'd0);
    read_entry(2'd0, 9'h031, "t7_e0");

    // Leading rest
    start_rec(5'd0);
    run(5'd0, 40);
    run(5'd8, 11);
    stop_rec();
`ifdef REC_LEAD_TRIM_EN
    check("t8_len", 32'(rec_len), 32'd1);
    read_entry(2'd0, 9'h081, "t8_e0");
`else
    check("t8_len", 32'(rec_len), 32'd2);
    read_entry(2'd0, 9'h004, "t8_e0");
    read_entry(2'd1, 9'h081, "t8_e1");
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
